fp_add_pipe: RTL and testbench

Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor. It is the next-generation accumulate adder for the MMM processing element and handles any EXPONENT/MANTISSA split.
- Adds round-to-nearest-even, an add/sub mode, and proper Inf/NaN propagation with status flags.
- Uses a valid/ready handshake with full backpressure, so it can sit between the multiplier and the partial-sum register.

---
 rtl/fp_add_pipe.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// Purpose: parametrised IEEE-754-style add/sub with RNE rounding, FTZ, Inf/NaN handling and status flags.
// Latency: 3 cycles (unpack/align, add + leading-zero count, normalise/round/pack), 1 result per cycle.
// Backpressure: all stages advance together only when the output register is empty or drained; in_ready mirrors that.
module fp_add_pipe #(
  parameter int EXPONENT   = 5,
  parameter int MANTISSA   = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_op,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_overflow,
  output logic                  out_invalid,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Significand layout: {carry, hidden, fraction, guard, round, sticky}
  localparam int W   = MANTISSA + 5;
  // Shiftable part of the smaller operand: {hidden, fraction, guard, round}
  localparam int XW  = MANTISSA + 3;
  localparam int LZW = $clog2(W) + 1;
  // Signed exponent wide enough for exp + 1 and exp - lzc without wrap
  localparam int EW  = ((EXPONENT > LZW) ? EXPONENT : LZW) + 2;
  localparam logic [EXPONENT-1:0]   EXP_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANTISSA-1){1'b0}}};
  localparam logic signed [EW-1:0]  EMAX     = EW'((1 << EXPONENT) - 1);

  generate
    if ((DATA_WIDTH != 1 + EXPONENT + MANTISSA) || (EXPONENT < 3) || (MANTISSA < 2)) begin : g_param_chk
      $error("fp_add_pipe: need DATA_WIDTH == 1+EXPONENT+MANTISSA, EXPONENT >= 3, MANTISSA >= 2");
    end
  endgenerate

  // Whole pipe moves in lockstep; bubbles are not collapsed
  logic w_adv;
  logic r_s3_vld;
  assign w_adv    = ~r_s3_vld | out_ready;
  assign in_ready = w_adv;

  // ---------------- Stage 1: unpack, classify, swap, align ----------------
  logic [EXPONENT-1:0] w_a_exp, w_b_exp, w_l_exp, w_s_exp, w_diff;
  logic [MANTISSA-1:0] w_a_man, w_b_man, w_a_manf, w_b_manf, w_l_man, w_s_man;
  logic                w_a_sign, w_b_sign, w_l_sign, w_s_sign, w_swap;
  logic                w_l_nz, w_s_nz;
  logic                w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_invalid, w_special;
  logic [DATA_WIDTH-1:0] w_spec_val;
  logic [XW-1:0]       w_s_ext, w_s_shift;
  logic [31:0]         w_diff32;
  logic                w_sticky;
  logic [W-1:0]        w_sig_l, w_sig_s;

  assign w_a_exp  = in_a[MANTISSA +: EXPONENT];
  assign w_b_exp  = in_b[MANTISSA +: EXPONENT];
  assign w_a_man  = in_a[MANTISSA-1:0];
  assign w_b_man  = in_b[MANTISSA-1:0];
  assign w_a_sign = in_a[DATA_WIDTH-1];
  // Subtraction is folded in here by flipping B's sign
  assign w_b_sign = in_b[DATA_WIDTH-1] ^ in_op;

  // Subnormals become signed zero: clearing the fraction is enough since exp is already 0
  assign w_a_manf = (w_a_exp == '0) ? '0 : w_a_man;
  assign w_b_manf = (w_b_exp == '0) ? '0 : w_b_man;

  assign w_swap   = {w_b_exp, w_b_manf} > {w_a_exp, w_a_manf};
  assign w_l_exp  = w_swap ? w_b_exp  : w_a_exp;
  assign w_s_exp  = w_swap ? w_a_exp  : w_b_exp;
  assign w_l_man  = w_swap ? w_b_manf : w_a_manf;
  assign w_s_man  = w_swap ? w_a_manf : w_b_manf;
  assign w_l_sign = w_swap ? w_b_sign : w_a_sign;
  assign w_s_sign = w_swap ? w_a_sign : w_b_sign;
  assign w_l_nz   = |w_l_exp;
  assign w_s_nz   = |w_s_exp;
  assign w_diff   = w_l_exp - w_s_exp;
  assign w_diff32 = 32'(w_diff);

  assign w_a_nan   = (w_a_exp == EXP_ONES) && (w_a_man != '0);
  assign w_b_nan   = (w_b_exp == EXP_ONES) && (w_b_man != '0);
  assign w_a_inf   = (w_a_exp == EXP_ONES) && (w_a_man == '0);
  assign w_b_inf   = (w_b_exp == EXP_ONES) && (w_b_man == '0);
  assign w_invalid = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_a_sign ^ w_b_sign));
  assign w_special = w_invalid | w_a_inf | w_b_inf;

  // Pick the forced result for NaN / Inf cases
  always_comb begin
    w_spec_val = QNAN;
    if (!w_invalid) begin
      if (w_a_inf) w_spec_val = {w_a_sign, EXP_ONES, {MANTISSA{1'b0}}};
      else         w_spec_val = {w_b_sign, EXP_ONES, {MANTISSA{1'b0}}};
    end
  end

  assign w_s_ext = {w_s_nz, w_s_man, 2'b00};

  // Right-shift the smaller significand; everything pushed below round collapses into sticky
  always_comb begin
    w_s_shift = '0;
    w_sticky  = 1'b0;
    if (w_diff32 >= XW) begin
      w_sticky = |w_s_ext;
    end else begin
      w_s_shift = w_s_ext >> w_diff;
      for (int i = 0; i < XW; i++) begin
        if (w_diff32 > 32'(i)) w_sticky = w_sticky | w_s_ext[i];
      end
    end
  end

  assign w_sig_l = {1'b0, w_l_nz, w_l_man, 3'b000};
  assign w_sig_s = {1'b0, w_s_shift, w_sticky};

  logic                  r_s1_vld, r_s1_sign, r_s1_sub, r_s1_special, r_s1_invalid;
  logic [EXPONENT-1:0]   r_s1_exp;
  logic [W-1:0]          r_s1_sig_l, r_s1_sig_s;
  logic [DATA_WIDTH-1:0] r_s1_spec_val;

  // Stage 1 register: aligned operands plus special-case decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld      <= 1'b0;
      r_s1_sign     <= 1'b0;
      r_s1_sub      <= 1'b0;
      r_s1_special  <= 1'b0;
      r_s1_invalid  <= 1'b0;
      r_s1_exp      <= '0;
      r_s1_sig_l    <= '0;
      r_s1_sig_s    <= '0;
      r_s1_spec_val <= '0;
    end else if (w_adv) begin
      r_s1_vld      <= in_valid;
      r_s1_sign     <= w_l_sign;
      r_s1_sub      <= w_l_sign ^ w_s_sign;
      r_s1_special  <= w_special;
      r_s1_invalid  <= w_invalid;
      r_s1_exp      <= w_l_exp;
      r_s1_sig_l    <= w_sig_l;
      r_s1_sig_s    <= w_sig_s;
      r_s1_spec_val <= w_spec_val;
    end
  end

  // ---------------- Stage 2: add/sub and leading-zero count ----------------
  logic [W-1:0]   w_sum;
  logic [LZW-1:0] w_lzc;
  logic           w_lz_found;

  // |large| >= |small| so the subtraction never goes negative
  assign w_sum = r_s1_sub ? (r_s1_sig_l - r_s1_sig_s) : (r_s1_sig_l + r_s1_sig_s);

  // Count zeros from the hidden-bit position downwards
  always_comb begin
    w_lzc      = '0;
    w_lz_found = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      if (!w_lz_found) begin
        if (w_sum[i]) w_lz_found = 1'b1;
        else          w_lzc      = w_lzc + LZW'(1);
      end
    end
  end

  logic                  r_s2_vld, r_s2_sign, r_s2_sub, r_s2_special, r_s2_invalid;
  logic [EXPONENT-1:0]   r_s2_exp;
  logic [W-1:0]          r_s2_sum;
  logic [LZW-1:0]        r_s2_lzc;
  logic [DATA_WIDTH-1:0] r_s2_spec_val;

  // Stage 2 register: raw sum and its normalisation distance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_vld      <= 1'b0;
      r_s2_sign     <= 1'b0;
      r_s2_sub      <= 1'b0;
      r_s2_special  <= 1'b0;
      r_s2_invalid  <= 1'b0;
      r_s2_exp      <= '0;
      r_s2_sum      <= '0;
      r_s2_lzc      <= '0;
      r_s2_spec_val <= '0;
    end else if (w_adv) begin
      r_s2_vld      <= r_s1_vld;
      r_s2_sign     <= r_s1_sign;
      r_s2_sub      <= r_s1_sub;
      r_s2_special  <= r_s1_special;
      r_s2_invalid  <= r_s1_invalid;
      r_s2_exp      <= r_s1_exp;
      r_s2_sum      <= w_sum;
      r_s2_lzc      <= w_lzc;
      r_s2_spec_val <= r_s1_spec_val;
    end
  end

  // ---------------- Stage 3: normalise, round, pack ----------------
  // w_norm is {hidden, fraction, guard, round, sticky}
  logic [W-2:0]          w_norm;
  logic signed [EW-1:0]  w_nexp, w_rexp;
  logic                  w_rnd;
  logic [MANTISSA+1:0]   w_mant_r;
  logic [MANTISSA-1:0]   w_frac;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ovf, w_inv;

  // Carry-out shifts right one (dropped bit joins sticky); otherwise shift left by the zero count
  always_comb begin
    if (r_s2_sum[W-1]) begin
      w_norm = {r_s2_sum[W-1:2], r_s2_sum[1] | r_s2_sum[0]};
      w_nexp = EW'(r_s2_exp) + EW'(1);
    end else begin
      w_norm = r_s2_sum[W-2:0] << r_s2_lzc;
      w_nexp = EW'(r_s2_exp) - EW'(r_s2_lzc);
    end
  end

  // Round to nearest, ties to even; a carry out of the significand bumps the exponent
  assign w_rnd    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mant_r = {1'b0, w_norm[W-2:3]} + {{(MANTISSA+1){1'b0}}, w_rnd};
  assign w_frac   = w_mant_r[MANTISSA+1] ? w_mant_r[MANTISSA:1] : w_mant_r[MANTISSA-1:0];
  assign w_rexp   = w_nexp + {{(EW-1){1'b0}}, w_mant_r[MANTISSA+1]};

  // Final result selection: specials, exact zero, overflow to Inf, underflow flush, normal
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_inv = 1'b0;
    if (r_s2_special) begin
      w_res = r_s2_spec_val;
      w_inv = r_s2_invalid;
    end else if (r_s2_sum == '0) begin
      // Exact cancellation is +0; only like-signed zeros keep their sign
      w_res = {~r_s2_sub & r_s2_sign, {(DATA_WIDTH-1){1'b0}}};
    end else if (w_rexp >= EMAX) begin
      w_res = {r_s2_sign, EXP_ONES, {MANTISSA{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_rexp[EW-1] || (w_rexp == '0)) begin
      w_res = {r_s2_sign, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      w_res = {r_s2_sign, w_rexp[EXPONENT-1:0], w_frac};
    end
  end

  logic [DATA_WIDTH-1:0] r_sum;
  logic                  r_ovf, r_inv;

  // Output register; flags are qualified by valid so bubbles never carry them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3_vld <= 1'b0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
      r_inv    <= 1'b0;
    end else if (w_adv) begin
      r_s3_vld <= r_s2_vld;
      r_sum    <= w_res;
      r_ovf    <= r_s2_vld & w_ovf;
      r_inv    <= r_s2_vld & w_inv;
    end
  end

  assign out_valid    = r_s3_vld;
  assign out_sum      = r_sum;
  assign out_overflow = r_ovf;
  assign out_invalid  = r_inv;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Purpose: directed checks of fp_add_pipe (half precision plus one single-precision case).
// Latency: expects results exactly 3 cycles after acceptance with out_ready high.
// Backpressure: exercises a 5-cycle output stall and an asynchronous reset mid-stream.
module tb_fp_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_op = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_overflow, out_invalid, out_valid;
  logic [15:0] out_sum;

  logic [31:0] in_a32 = '0, in_b32 = '0;
  logic        in_op32 = 1'b0, in_valid32 = 1'b0, out_ready32 = 1'b1;
  logic        in_ready32, out_overflow32, out_invalid32, out_valid32;
  logic [31:0] out_sum32;

  fp_add_pipe #(.EXPONENT(5), .MANTISSA(10), .DATA_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_valid(in_valid), .in_ready(in_ready), .out_sum(out_sum),
    .out_overflow(out_overflow), .out_invalid(out_invalid),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  fp_add_pipe #(.EXPONENT(8), .MANTISSA(23), .DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_a(in_a32), .in_b(in_b32), .in_op(in_op32),
    .in_valid(in_valid32), .in_ready(in_ready32), .out_sum(out_sum32),
    .out_overflow(out_overflow32), .out_invalid(out_invalid32),
    .out_valid(out_valid32), .out_ready(out_ready32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation: checks acceptance, 3-cycle latency, result and flags
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input logic [15:0] exp_sum,
                         input logic exp_ovf, input logic exp_inv);
    int cnt;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check_eq({tag, "_latency"}, 32'(cnt), 32'd3);
    check_eq({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check_eq({tag, "_ovf"}, 32'(out_overflow), 32'(exp_ovf));
    check_eq({tag, "_inv"}, 32'(out_invalid), 32'(exp_inv));
  endtask

  // Hand-computed stream for the backpressure test
  logic [15:0] bp_a [6] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4400, 16'h4800, 16'h4800};
  logic [15:0] bp_b [6] = '{16'h3C00, 16'h4000, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00};
  logic        bp_op[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] bp_e [6] = '{16'h4000, 16'h4400, 16'h4200, 16'h4500, 16'h4880, 16'h4700};

  int          sent, recv, stall, iter, seen, cnt32;
  logic [15:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_sum", 32'(out_sum), 32'd0);
    check_eq("rst_ovf", 32'(out_overflow), 32'd0);
    check_eq("rst_inv", 32'(out_invalid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid32", 32'(out_valid32), 32'd0);
    rst = 1'b0;

    // Directed vectors
    run_one("add_basic",   16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0);
    run_one("cancel_sub",  16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0);
    run_one("mixed_sign",  16'h4200, 16'hBC00, 1'b0, 16'h4000, 1'b0, 1'b0);
    run_one("tie_even",    16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, 1'b0);
    run_one("tie_odd",     16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b0);
    run_one("lsb_exact",   16'h3C00, 16'h1400, 1'b0, 16'h3C01, 1'b0, 1'b0);
    run_one("overflow",    16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0);
    run_one("inf_m_inf",   16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b0, 1'b1);
    run_one("inf_finite",  16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, 1'b0);
    run_one("ftz",         16'h0001, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 1'b0);
    run_one("neg_zeros",   16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0);

    // Backpressure: stream 6 ops, stall the output 5 cycles once the first result shows
    sent = 0; recv = 0; stall = 0; iter = 0; held = '0;
    while (recv < 6 && iter < 80) begin
      @(negedge clk);
      iter++;
      if (out_valid && stall < 5) begin
        if (stall == 0) held = out_sum;
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_a = bp_a[sent]; in_b = bp_b[sent]; in_op = bp_op[sent];
      end
      #1;
      if (!out_ready) begin
        check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
        if (stall > 1) check_eq("bp_sum_hold", 32'(out_sum), 32'(held));
      end
      if (out_valid && out_ready) begin
        check_eq($sformatf("bp_res%0d", recv), 32'(out_sum), 32'(bp_e[recv]));
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    check_eq("bp_result_count", 32'(recv), 32'd6);
    check_eq("bp_stall_cycles", 32'(stall), 32'd5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("bp_no_extra", 32'(seen), 32'd0);

    // Asynchronous reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_a = bp_a[k]; in_b = bp_b[k]; in_op = bp_op[k]; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", 32'(out_valid), 32'd0);
    check_eq("rst_async_sum", 32'(out_sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("rst_no_stale", 32'(seen), 32'd0);
    run_one("rst_rerun", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0);

    // Single-precision instance
    @(negedge clk);
    in_a32 = 32'h3F80_0000; in_b32 = 32'h4000_0000; in_op32 = 1'b0; in_valid32 = 1'b1;
    #1;
    check_eq("sp_in_ready", 32'(in_ready32), 32'd1);
    @(negedge clk);
    in_valid32 = 1'b0;
    cnt32 = 1;
    while (!out_valid32 && cnt32 < 10) begin
      @(negedge clk);
      cnt32++;
    end
    check_eq("sp_latency", 32'(cnt32), 32'd3);
    check_eq("sp_sum", out_sum32, 32'h4040_0000);
    check_eq("sp_ovf", 32'(out_overflow32), 32'd0);
    check_eq("sp_inv", 32'(out_invalid32), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
